mini_alu_exec: RTL and testbench

Parametrised execution unit for the next-generation MiniAlu core. It replaces the single-cycle combinational ALU case statement with a registered, handshaked unit. Single-cycle ops (add, sub, logic) complete in one cycle. Multiplies (unsigned and signed) run on an iterative shift-add engine taking WIDTH+1 cycles, which replaces the broken combinational IMUL chain. It sits between the operand-forwarding muxes and the data-RAM write port; the decode stage stalls on `oReady`.

---
 rtl/mini_alu_exec_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 84 ++++++++
 rtl/mini_alu_exec.sv | 120 ++++++++++++
 tb/tb_mini_alu_exec.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_alu_exec_pkg.sv
// Shared opcode encoding, multiplier FSM states and opcode helpers for the
// MiniAlu execution unit.
package mini_alu_exec_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
   localparam logic [OP_W-1:0] OP_AND  = 4'd3;
   localparam logic [OP_W-1:0] OP_OR   = 4'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd6;
   localparam logic [OP_W-1:0] OP_SMUL = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_FIX
   } mul_state_e;

   function automatic logic is_mul(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_SMUL);
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH add/shift iterations followed by one
// FIX cycle that applies the sign of a signed multiply.
module seq_multiplier
   import mini_alu_exec_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     iA,
   input  logic [WIDTH-1:0]     iB,
   input  logic                 iSigned,
   output logic                 oBusy,
   output logic                 oDone,
   output logic [2*WIDTH-1:0]   oProduct
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   mul_state_e                state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2*WIDTH-1:0]        mcand_q;
   logic [2*WIDTH-1:0]        acc_q;
   logic [WIDTH-1:0]          mplier_q;
   logic                      neg_q;

   logic signed [WIDTH-1:0]   a_s, b_s, a_neg, b_neg;
   logic [WIDTH-1:0]          a_mag, b_mag;

   // The most negative operand negates to itself, which read unsigned is
   // exactly its magnitude.
   always_comb begin
      a_s   = iA;
      b_s   = iB;
      a_neg = -a_s;
      b_neg = -b_s;
      a_mag = (iSigned && a_s[WIDTH-1]) ? $unsigned(a_neg) : iA;
      b_mag = (iSigned && b_s[WIDTH-1]) ? $unsigned(b_neg) : iB;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_MUL;
                  cnt_q    <= CNT_W'(WIDTH - 1);
                  mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                  mplier_q <= b_mag;
                  acc_q    <= '0;
                  neg_q    <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
               end
            end
            ST_MUL: begin
               if (mplier_q[0]) begin
                  acc_q <= acc_q + mcand_q;
               end
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               if (cnt_q == '0) begin
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_FIX:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign oBusy    = (state_q != ST_IDLE);
   assign oDone    = (state_q == ST_FIX);
   assign oProduct = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mini_alu_exec.sv
// Registered, handshaked MiniAlu execution unit: one-cycle add/sub/logic ops
// and a multi-cycle multiplier sharing one result and flag register set.
module mini_alu_exec
   import mini_alu_exec_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iValid,
   output logic                 oReady,
   input  logic [OP_W-1:0]      iOperation,
   input  logic [WIDTH-1:0]     iSourceData0,
   input  logic [WIDTH-1:0]     iSourceData1,
   input  logic [ADDR_W-1:0]    iDestination,
   output logic                 oResultValid,
   output logic [2*WIDTH-1:0]   oResult,
   output logic                 oWide,
   output logic [ADDR_W-1:0]    oDestination,
   output logic                 oZero,
   output logic                 oNegative,
   output logic                 oCarry,
   output logic                 oIllegal
);

   logic                 accept;
   logic                 mul_busy, mul_done;
   logic [2*WIDTH-1:0]   mul_prod;
   logic [WIDTH:0]       alu_res_d;
   logic                 alu_hit, alu_carry;

   logic                 valid_q, wide_q, zero_q, neg_q, carry_q, illegal_q;
   logic [2*WIDTH-1:0]   result_q;
   logic [ADDR_W-1:0]    dest_q, pend_dest_q;

   assign oReady = ~mul_busy;
   assign accept = iValid && oReady;

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (accept && is_mul(iOperation)),
      .iA       (iSourceData0),
      .iB       (iSourceData1),
      .iSigned  (iOperation == OP_SMUL),
      .oBusy    (mul_busy),
      .oDone    (mul_done),
      .oProduct (mul_prod)
   );

   // Single-cycle ops are evaluated one bit wider so bit WIDTH is carry/borrow.
   always_comb begin
      alu_res_d = '0;
      alu_hit   = 1'b1;
      alu_carry = 1'b0;
      case (iOperation)
         OP_ADD: begin
            alu_res_d = {1'b0, iSourceData0} + {1'b0, iSourceData1};
            alu_carry = alu_res_d[WIDTH];
         end
         OP_SUB: begin
            alu_res_d = {1'b0, iSourceData1} - {1'b0, iSourceData0};
            alu_carry = alu_res_d[WIDTH];
         end
         OP_AND:  alu_res_d = {1'b0, iSourceData0 & iSourceData1};
         OP_OR:   alu_res_d = {1'b0, iSourceData0 | iSourceData1};
         OP_XOR:  alu_res_d = {1'b0, iSourceData0 ^ iSourceData1};
         default: alu_hit   = 1'b0;
      endcase
   end

   // accept and mul_done never coincide: the unit is not ready during FIX.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         valid_q     <= 1'b0;
         illegal_q   <= 1'b0;
         result_q    <= '0;
         wide_q      <= 1'b0;
         dest_q      <= '0;
         pend_dest_q <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         illegal_q <= accept & iOperation[OP_W-1];
         if (accept && is_mul(iOperation)) begin
            pend_dest_q <= iDestination;
         end
         if (accept && alu_hit) begin
            valid_q  <= 1'b1;
            result_q <= {{WIDTH{1'b0}}, alu_res_d[WIDTH-1:0]};
            wide_q   <= 1'b0;
            dest_q   <= iDestination;
            zero_q   <= (alu_res_d[WIDTH-1:0] == '0);
            neg_q    <= alu_res_d[WIDTH-1];
            carry_q  <= alu_carry;
         end else if (mul_done) begin
            valid_q  <= 1'b1;
            result_q <= mul_prod;
            wide_q   <= 1'b1;
            dest_q   <= pend_dest_q;
            zero_q   <= (mul_prod == '0);
            neg_q    <= mul_prod[2*WIDTH-1];
            carry_q  <= 1'b0;
         end
      end
   end

   assign oResultValid = valid_q;
   assign oResult      = result_q;
   assign oWide        = wide_q;
   assign oDestination = dest_q;
   assign oZero        = zero_q;
   assign oNegative    = neg_q;
   assign oCarry       = carry_q;
   assign oIllegal     = illegal_q;

endmodule

// File: tb/tb_mini_alu_exec.sv
// Scoreboard bench for mini_alu_exec: a 16-bit and an 8-bit instance driven
// with directed vectors whose expected results are hand-computed constants.
module tb_mini_alu_exec;

   typedef struct {
      logic [31:0] res;
      logic        wide;
      logic [7:0]  dest;
      logic        z, n, c;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ill16_cnt = 0;
   int ill8_cnt  = 0;

   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;

   // 16-bit instance
   logic        rst16_n = 1'b0;
   logic        v16 = 1'b0;
   logic [3:0]  op16 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [7:0]  d16 = '0;
   logic        r16_ready, r16_valid, r16_wide, r16_z, r16_n, r16_c, r16_ill;
   logic [31:0] r16_res;
   logic [7:0]  r16_dest;

   // 8-bit instance
   logic        rst8_n = 1'b0;
   logic        v8 = 1'b0;
   logic [3:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  d8 = '0;
   logic        r8_ready, r8_valid, r8_wide, r8_z, r8_n, r8_c, r8_ill;
   logic [15:0] r8_res;
   logic [7:0]  r8_dest;

   mini_alu_exec #(.WIDTH(16), .ADDR_W(8)) u16 (
      .Clock(clk), .Reset(rst16_n), .iValid(v16), .oReady(r16_ready),
      .iOperation(op16), .iSourceData0(a16), .iSourceData1(b16),
      .iDestination(d16), .oResultValid(r16_valid), .oResult(r16_res),
      .oWide(r16_wide), .oDestination(r16_dest), .oZero(r16_z),
      .oNegative(r16_n), .oCarry(r16_c), .oIllegal(r16_ill)
   );

   mini_alu_exec #(.WIDTH(8), .ADDR_W(8)) u8 (
      .Clock(clk), .Reset(rst8_n), .iValid(v8), .oReady(r8_ready),
      .iOperation(op8), .iSourceData0(a8), .iSourceData1(b8),
      .iDestination(d8), .oResultValid(r8_valid), .oResult(r8_res),
      .oWide(r8_wide), .oDestination(r8_dest), .oZero(r8_z),
      .oNegative(r8_n), .oCarry(r8_c), .oIllegal(r8_ill)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input bit is8, input logic [31:0] res, input logic wide,
                       input logic [7:0] dest, input logic z, input logic n, input logic c);
      exp_t e;
      e.res = res; e.wide = wide; e.dest = dest; e.z = z; e.n = n; e.c = c;
      if (is8) q8.push_back(e);
      else     q16.push_back(e);
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic issue(input bit is8, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] d);
      if (is8) begin
         check("u8_ready_before_accept", {63'd0, r8_ready}, 64'd1);
         v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; d8 = d;
      end else begin
         check("u16_ready_before_accept", {63'd0, r16_ready}, 64'd1);
         v16 = 1'b1; op16 = op; a16 = a; b16 = b; d16 = d;
      end
      @(posedge clk); #1;
      v8  = 1'b0;
      v16 = 1'b0;
   endtask

   // lat = edges after the accepting edge until oResultValid is seen;
   // low = cycles with oReady low before that.
   task automatic wait_valid(input bit is8, output int lat, output int low);
      lat = 0;
      low = 0;
      while (!(is8 ? r8_valid : r16_valid) && lat < 200) begin
         if (!(is8 ? r8_ready : r16_ready)) low++;
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no oResultValid within 200 cycles, expected one",
                  is8 ? "u8_wait_valid" : "u16_wait_valid");
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (r16_ill) ill16_cnt++;
      if (r16_valid) begin
         if (q16.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL u16_unexpected_valid: got oResultValid=1 (result 0x%0h), expected 0", r16_res);
         end else begin
            e16 = q16.pop_front();
            check("u16_result", {32'd0, r16_res}, {32'd0, e16.res});
            check("u16_wide",   {63'd0, r16_wide}, {63'd0, e16.wide});
            check("u16_dest",   {56'd0, r16_dest}, {56'd0, e16.dest});
            check("u16_zero",   {63'd0, r16_z}, {63'd0, e16.z});
            check("u16_neg",    {63'd0, r16_n}, {63'd0, e16.n});
            check("u16_carry",  {63'd0, r16_c}, {63'd0, e16.c});
         end
      end
   end

   always @(negedge clk) begin
      if (r8_ill) ill8_cnt++;
      if (r8_valid) begin
         if (q8.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL u8_unexpected_valid: got oResultValid=1 (result 0x%0h), expected 0", r8_res);
         end else begin
            e8 = q8.pop_front();
            check("u8_result", {48'd0, r8_res}, {32'd0, e8.res});
            check("u8_wide",   {63'd0, r8_wide}, {63'd0, e8.wide});
            check("u8_dest",   {56'd0, r8_dest}, {56'd0, e8.dest});
            check("u8_zero",   {63'd0, r8_z}, {63'd0, e8.z});
            check("u8_neg",    {63'd0, r8_n}, {63'd0, e8.n});
            check("u8_carry",  {63'd0, r8_c}, {63'd0, e8.c});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, low, vcount;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {63'd0, r16_ready}, 64'd1);
      check("rst_valid",  {63'd0, r16_valid}, 64'd0);
      check("rst_result", {32'd0, r16_res}, 64'd0);
      check("rst_wide",   {63'd0, r16_wide}, 64'd0);
      check("rst_dest",   {56'd0, r16_dest}, 64'd0);
      check("rst_flags",  {61'd0, r16_z, r16_n, r16_c}, 64'd0);
      check("rst_illegal", {63'd0, r16_ill}, 64'd0);
      rst16_n = 1'b1;
      rst8_n  = 1'b1;
      @(posedge clk); #1;

      // ADD with carry-out wrapping to zero
      push(0, 32'h0000_0000, 0, 8'h11, 1, 0, 1);
      issue(0, 4'd1, 16'h0001, 16'hFFFF, 8'h11);
      wait_valid(0, lat, low);
      check("add_latency", lat, 64'd0);

      // SUB (B-A with borrow) then ADD back-to-back
      push(0, 32'h0000_FFFE, 0, 8'h22, 0, 1, 1);
      push(0, 32'h0000_0004, 0, 8'h23, 0, 0, 0);
      check("b2b_ready", {63'd0, r16_ready}, 64'd1);
      v16 = 1'b1; op16 = 4'd2; a16 = 16'd5; b16 = 16'd3; d16 = 8'h22;
      @(posedge clk); #1;
      check("b2b_valid_first", {63'd0, r16_valid}, 64'd1);
      op16 = 4'd1; a16 = 16'd2; b16 = 16'd2; d16 = 8'h23;
      @(posedge clk); #1;
      v16 = 1'b0;
      check("b2b_valid_second", {63'd0, r16_valid}, 64'd1);

      // Logic ops
      push(0, 32'h0000_00F0, 0, 8'h31, 0, 0, 0);
      issue(0, 4'd3, 16'hF0F0, 16'h0FF0, 8'h31);
      push(0, 32'h0000_FFF0, 0, 8'h32, 0, 1, 0);
      issue(0, 4'd4, 16'hF0F0, 16'h0FF0, 8'h32);
      push(0, 32'h0000_F0F0, 0, 8'h33, 0, 1, 0);
      issue(0, 4'd5, 16'hFF00, 16'h0FF0, 8'h33);
      push(0, 32'h0000_0000, 0, 8'h34, 1, 0, 0);
      issue(0, 4'd5, 16'h5A5A, 16'h5A5A, 8'h34);

      // NOP: no result, flags and result hold
      issue(0, 4'd0, 16'h1234, 16'h1234, 8'h77);
      check("nop_no_valid", {63'd0, r16_valid}, 64'd0);
      @(posedge clk); #1;
      check("nop_hold_result", {32'd0, r16_res}, 64'd0);
      check("nop_hold_zero", {63'd0, r16_z}, 64'd1);
      check("nop_hold_dest", {56'd0, r16_dest}, 64'h34);

      // Unsigned MUL with an op held on iValid throughout
      push(0, 32'hFFFE_0001, 1, 8'h44, 0, 1, 0);
      push(0, 32'h0000_000F, 0, 8'h45, 0, 0, 0);
      issue(0, 4'd6, 16'hFFFF, 16'hFFFF, 8'h44);
      v16 = 1'b1; op16 = 4'd1; a16 = 16'd7; b16 = 16'd8; d16 = 8'h45;
      wait_valid(0, lat, low);
      check("mul_latency", lat, 64'd17);
      check("mul_ready_low_cycles", low, 64'd17);
      check("mul_ready_with_result", {63'd0, r16_ready}, 64'd1);
      @(posedge clk); #1;
      v16 = 1'b0;
      check("held_add_valid", {63'd0, r16_valid}, 64'd1);

      // Signed multiplies and a zero product
      push(0, 32'hFFFF_FFF1, 1, 8'h51, 0, 1, 0);
      issue(0, 4'd7, 16'hFFFD, 16'h0005, 8'h51);
      wait_valid(0, lat, low);
      check("smul_latency", lat, 64'd17);
      push(0, 32'h0000_0000, 1, 8'h52, 1, 0, 0);
      issue(0, 4'd6, 16'h0000, 16'h1234, 8'h52);
      wait_valid(0, lat, low);
      push(0, 32'h0000_8000, 1, 8'h53, 0, 0, 0);
      issue(0, 4'd7, 16'h8000, 16'hFFFF, 8'h53);
      wait_valid(0, lat, low);
      push(0, 32'hC000_8000, 1, 8'h54, 0, 1, 0);
      issue(0, 4'd7, 16'h7FFF, 16'h8000, 8'h54);
      wait_valid(0, lat, low);
      @(posedge clk); #1;

      // Reset during iteration 8 of a MUL
      issue(0, 4'd6, 16'h1234, 16'h5678, 8'h66);
      repeat (7) @(posedge clk);
      #1;
      rst16_n = 1'b0;
      #1;
      check("abort_ready",  {63'd0, r16_ready}, 64'd1);
      check("abort_valid",  {63'd0, r16_valid}, 64'd0);
      check("abort_result", {32'd0, r16_res}, 64'd0);
      check("abort_wide",   {63'd0, r16_wide}, 64'd0);
      check("abort_dest",   {56'd0, r16_dest}, 64'd0);
      check("abort_flags",  {61'd0, r16_z, r16_n, r16_c}, 64'd0);
      @(posedge clk); #1;
      rst16_n = 1'b1;
      vcount = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (r16_valid) vcount++;
      end
      check("abort_no_result", vcount, 64'd0);
      push(0, 32'h0000_0007, 0, 8'h61, 0, 0, 0);
      issue(0, 4'd1, 16'd3, 16'd4, 8'h61);
      wait_valid(0, lat, low);
      check("post_abort_latency", lat, 64'd0);

      // WIDTH=8 instance
      push(1, 32'h0000_FE01, 1, 8'h81, 0, 1, 0);
      issue(1, 4'd6, 16'h00FF, 16'h00FF, 8'h81);
      wait_valid(1, lat, low);
      check("u8_mul_latency", lat, 64'd9);
      check("u8_mul_ready_low_cycles", low, 64'd9);
      push(1, 32'h0000_4000, 1, 8'h82, 0, 0, 0);
      issue(1, 4'd7, 16'h0080, 16'h0080, 8'h82);
      wait_valid(1, lat, low);
      push(1, 32'h0000_0000, 0, 8'h85, 1, 0, 0);
      issue(1, 4'd2, 16'h0000, 16'h0000, 8'h85);
      push(1, 32'h0000_00F1, 0, 8'h83, 0, 1, 1);
      issue(1, 4'd2, 16'h0010, 16'h0001, 8'h83);
      issue(1, 4'hC, 16'h00AA, 16'h0055, 8'h84);
      check("u8_illegal_pulse", {63'd0, r8_ill}, 64'd1);
      check("u8_illegal_no_valid", {63'd0, r8_valid}, 64'd0);
      @(posedge clk); #1;
      check("u8_illegal_one_cycle", {63'd0, r8_ill}, 64'd0);
      check("u8_illegal_hold_result", {48'd0, r8_res}, 64'h00F1);
      check("u8_illegal_hold_neg", {63'd0, r8_n}, 64'd1);
      check("u8_illegal_hold_carry", {63'd0, r8_c}, 64'd1);
      check("u8_illegal_hold_dest", {56'd0, r8_dest}, 64'h83);

      repeat (5) @(posedge clk);
      #1;
      check("u16_results_drained", q16.size(), 64'd0);
      check("u8_results_drained", q8.size(), 64'd0);
      check("u16_illegal_count", ill16_cnt, 64'd0);
      check("u8_illegal_count", ill8_cnt, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
